// File: rtl/reg_op_sequencer_pkg.sv
// Shared definitions for the register-op sequencer: address width, opcodes,
// FSM state type and the flag-update rule.
package reg_op_sequencer_pkg;

  localparam int ADDR_W = 2;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDI = 3'b001;
  localparam logic [2:0] OP_MOV = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_EXEC  = 2'b10,
    S_WRITE = 2'b11
  } state_e;

  // Arithmetic and logic ops update zf/cf; NOP, LDI and MOV leave them alone.
  function automatic logic updates_flags(input logic [2:0] op);
    return op >= OP_ADD;
  endfunction

endpackage

// File: rtl/reg_op_sequencer_seq_alu.sv
// Combinational ALU for the register-op sequencer. Produces the write-back
// value plus carry/borrow and zero indications for every opcode.
module seq_alu
  import reg_op_sequencer_pkg::*;
#(
  parameter int Size = 8
) (
  input  logic [2:0]      op,
  input  logic [Size-1:0] opA,
  input  logic [Size-1:0] opB,
  input  logic [Size-1:0] imm,
  output logic [Size-1:0] result,
  output logic            carry,
  output logic            zero
);

  logic [Size:0] wide;

  // One extra bit: carry-out for ADD, borrow (opA < opB) for SUB, 0 for logic ops.
  always_comb begin
    wide = '0;
    case (op)
      OP_NOP:  wide = '0;
      OP_LDI:  wide = {1'b0, imm};
      OP_MOV:  wide = {1'b0, opB};
      OP_ADD:  wide = {1'b0, opA} + {1'b0, opB};
      OP_SUB:  wide = {1'b0, opA} - {1'b0, opB};
      OP_AND:  wide = {1'b0, opA & opB};
      OP_OR:   wide = {1'b0, opA | opB};
      OP_XOR:  wide = {1'b0, opA ^ opB};
      default: wide = '0;
    endcase
    result = wide[Size-1:0];
    carry  = wide[Size];
    zero   = (wide[Size-1:0] == '0);
  end

endmodule

// File: rtl/reg_op_sequencer.sv
// Four-cycle register-op sequencer in front of the register bank:
// IDLE (accept) -> READ (operands) -> EXEC (ALU, flags) -> WRITE (bank update).
module reg_op_sequencer
  import reg_op_sequencer_pkg::*;
#(
  parameter int Size = 8,
  parameter int nreg = 4
) (
  input  logic              clk,
  input  logic              clk_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] src,
  input  logic [Size-1:0]   imm,
  output logic [ADDR_W-1:0] a1,
  output logic [ADDR_W-1:0] a2,
  output logic              we,
  output logic [Size-1:0]   wd,
  input  logic [Size-1:0]   rd1,
  input  logic [Size-1:0]   rd2,
  output logic              done,
  output logic              zf,
  output logic              cf
);

  if (nreg != (1 << ADDR_W)) begin : g_nreg_check
    $error("reg_op_sequencer: nreg must equal 2**ADDR_W");
  end

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [Size-1:0]   imm_q, imm_d;
  logic [Size-1:0]   opa_q, opa_d;
  logic [Size-1:0]   opb_q, opb_d;
  logic [Size-1:0]   wd_q, wd_d;
  logic              zf_q, zf_d;
  logic              cf_q, cf_d;

  logic [Size-1:0]   alu_result;
  logic              alu_carry;
  logic              alu_zero;

  seq_alu #(.Size(Size)) u_alu (
    .op     (op_q),
    .opA    (opa_q),
    .opB    (opb_q),
    .imm    (imm_q),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk or negedge clk_n) begin
    if (!clk_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      dst_q   <= '0;
      src_q   <= '0;
      imm_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      wd_q    <= '0;
      zf_q    <= 1'b0;
      cf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      imm_q   <= imm_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      wd_q    <= wd_d;
      zf_q    <= zf_d;
      cf_q    <= cf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dst_d   = dst_q;
    src_d   = src_q;
    imm_d   = imm_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    wd_d    = wd_q;
    zf_d    = zf_q;
    cf_d    = cf_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = op;
          dst_d   = dst;
          src_d   = src;
          imm_d   = imm;
          state_d = S_READ;
        end
      end
      S_READ: begin
        opa_d   = rd1;
        opb_d   = rd2;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        wd_d = alu_result;
        if (updates_flags(op_q)) begin
          zf_d = alu_zero;
          cf_d = alu_carry;
        end
        state_d = S_WRITE;
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode the state register directly, so an async reset drops we at once.
  always_comb begin
    in_ready = (state_q == S_IDLE);
    we       = (state_q == S_WRITE) && (op_q != OP_NOP);
    done     = (state_q == S_WRITE);
    a1       = dst_q;
    a2       = src_q;
    wd       = wd_q;
    zf       = zf_q;
    cf       = cf_q;
  end

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Directed bench for reg_op_sequencer with a behavioural 4x8 register bank.
module tb_reg_op_sequencer;

  logic       clk = 1'b0;
  logic       clk_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [1:0] dst, src;
  logic [7:0] imm;
  logic [1:0] a1, a2;
  logic       we;
  logic [7:0] wd;
  logic [7:0] rd1, rd2;
  logic       done, zf, cf;

  int total = 0;
  int bad   = 0;
  int cyc_cnt = 0;

  logic [7:0] bank [4] = '{default: 8'h00};

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(posedge clk) if (we) bank[a1] <= wd;
  assign rd1 = bank[a1];
  assign rd2 = bank[a2];

  reg_op_sequencer #(.Size(8), .nreg(4)) dut (
    .clk      (clk),
    .clk_n    (clk_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .dst      (dst),
    .src      (src),
    .imm      (imm),
    .a1       (a1),
    .a2       (a2),
    .we       (we),
    .wd       (wd),
    .rd1      (rd1),
    .rd2      (rd2),
    .done     (done),
    .zf       (zf),
    .cf       (cf)
  );

  typedef struct {
    logic [2:0] op;
    logic [1:0] dst;
    logic [1:0] src;
    logic [7:0] imm;
    logic [7:0] exp_val;
    logic       exp_zf;
    logic       exp_cf;
  } rec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input rec_t r);
    op  = r.op;
    dst = r.dst;
    src = r.src;
    imm = r.imm;
  endtask

  // Entered on a negedge in IDLE; returns on the negedge after WRITE.
  task automatic issue(input rec_t r, input string name);
    logic [2:0] dseq, rseq, wseq;
    int unsigned waited;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({name, ".ready"}, 32'(in_ready), 32'd1);
    load(r);
    in_valid = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      dseq[i] = done;
      rseq[i] = in_ready;
      wseq[i] = we;
    end
    chk({name, ".done_seq"}, 32'(dseq), 32'b100);
    chk({name, ".ready_seq"}, 32'(rseq), 32'b000);
    chk({name, ".we_seq"}, 32'(wseq), (r.op == 3'b000) ? 32'b000 : 32'b100);
    @(negedge clk);
    chk({name, ".reg"}, 32'(bank[r.dst]), 32'(r.exp_val));
    chk({name, ".flags"}, 32'({zf, cf}), 32'({r.exp_zf, r.exp_cf}));
  endtask

  rec_t vec [15];
  rec_t hold [3];
  rec_t r6;
  int   acc [3];
  int   idx;

  initial begin
    // op, dst, src, imm, expected dst value, zf, cf
    vec[0]  = '{3'b001, 2'd0, 2'd0, 8'h7F, 8'h7F, 1'b0, 1'b0}; // LDI r0,7F
    vec[1]  = '{3'b001, 2'd1, 2'd0, 8'h01, 8'h01, 1'b0, 1'b0}; // LDI r1,01
    vec[2]  = '{3'b011, 2'd0, 2'd1, 8'h00, 8'h80, 1'b0, 1'b0}; // ADD r0,r1
    vec[3]  = '{3'b001, 2'd2, 2'd0, 8'hFF, 8'hFF, 1'b0, 1'b0}; // LDI r2,FF
    vec[4]  = '{3'b011, 2'd2, 2'd1, 8'h00, 8'h00, 1'b1, 1'b1}; // ADD r2,r1
    vec[5]  = '{3'b010, 2'd3, 2'd2, 8'h00, 8'h00, 1'b1, 1'b1}; // MOV r3,r2
    vec[6]  = '{3'b100, 2'd1, 2'd0, 8'h00, 8'h81, 1'b0, 1'b1}; // SUB r1,r0
    vec[7]  = '{3'b111, 2'd1, 2'd1, 8'h00, 8'h00, 1'b1, 1'b0}; // XOR r1,r1
    vec[8]  = '{3'b001, 2'd2, 2'd0, 8'hF0, 8'hF0, 1'b1, 1'b0}; // LDI r2,F0
    vec[9]  = '{3'b110, 2'd2, 2'd0, 8'h00, 8'hF0, 1'b0, 1'b0}; // OR r2,r0
    vec[10] = '{3'b101, 2'd2, 2'd3, 8'h00, 8'h00, 1'b1, 1'b0}; // AND r2,r3
    vec[11] = '{3'b011, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1}; // ADD r0,r0
    vec[12] = '{3'b001, 2'd1, 2'd0, 8'h3C, 8'h3C, 1'b1, 1'b1}; // LDI r1,3C
    vec[13] = '{3'b100, 2'd1, 2'd2, 8'h00, 8'h3C, 1'b0, 1'b0}; // SUB r1,r2
    vec[14] = '{3'b000, 2'd1, 2'd0, 8'h55, 8'h3C, 1'b0, 1'b0}; // NOP
    hold[0] = '{3'b001, 2'd0, 2'd0, 8'h11, 8'h11, 1'b0, 1'b0};
    hold[1] = '{3'b001, 2'd1, 2'd0, 8'h22, 8'h22, 1'b0, 1'b0};
    hold[2] = '{3'b011, 2'd0, 2'd1, 8'h00, 8'h33, 1'b0, 1'b0};
    r6      = '{3'b001, 2'd3, 2'd0, 8'hAA, 8'h00, 1'b0, 1'b0};

    clk_n = 1'b0; in_valid = 1'b0; op = '0; dst = '0; src = '0; imm = '0;
    repeat (3) @(negedge clk);
    chk("in_reset.ready_we", 32'({in_ready, we}), 32'b10);
    clk_n = 1'b1;

    // Idle after reset: {in_ready, we, done, zf, cf, wd}
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d", i), 32'({in_ready, we, done, zf, cf, wd}), 32'({5'b10000, 8'h00}));
    end

    for (int i = 0; i < 15; i++) issue(vec[i], $sformatf("vec%0d", i));

    // in_valid held high across three instructions
    idx = 0;
    load(hold[0]);
    in_valid = 1'b1;
    for (int k = 0; k < 40 && idx < 3; k++) begin
      if (in_ready) begin
        acc[idx] = cyc_cnt;
        idx++;
      end
      @(negedge clk);
      if (idx < 3) load(hold[idx]);
      else in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk("hold.accepts", 32'(idx), 32'd3);
    chk("hold.gap01", 32'(acc[1] - acc[0]), 32'd4);
    chk("hold.gap12", 32'(acc[2] - acc[1]), 32'd4);
    repeat (3) @(negedge clk);
    chk("hold.r0", 32'(bank[0]), 32'h33);
    chk("hold.r1", 32'(bank[1]), 32'h22);
    chk("hold.flags", 32'({zf, cf}), 32'b00);

    // Reset pulse during WRITE of LDI r3,AA
    chk("abort.ready", 32'(in_ready), 32'd1);
    load(r6);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort.pre_we_done", 32'({we, done}), 32'b11);
    clk_n = 1'b0;
    #1;
    chk("abort.in_reset", 32'({we, done, in_ready, wd}), 32'({3'b001, 8'h00}));
    #1;
    clk_n = 1'b1;
    @(negedge clk);
    chk("abort.r3", 32'(bank[3]), 32'h00);
    chk("abort.idle", 32'({in_ready, done, we, zf, cf}), 32'b10000);
    issue('{3'b000, 2'd3, 2'd2, 8'hAA, 8'h00, 1'b0, 1'b0}, "nop_after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
